// File: rtl/strobe_rate_meter_pkg.sv
// Shared types and sizing helpers for the strobe rate meter.
package strobe_rate_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQ,
      ST_LOCKED
   } state_t;

   function automatic int unsigned run_width(input int unsigned lock_count);
      return $clog2(lock_count + 1);
   endfunction

   // Last counter value at which a strobe still yields a valid period.
   function automatic int unsigned cnt_max(input int unsigned width);
      return (1 << width) - 2;
   endfunction

endpackage

// File: rtl/strobe_period_counter.sv
// Cycle counter since the last strobe; presents the period and terminal flag.
module strobe_period_counter
   import strobe_rate_meter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_stb,
   output logic [WIDTH-1:0] o_period,
   output logic             o_terminal
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear || i_stb)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + WIDTH'(1);
   end

   assign o_period   = r_cnt + WIDTH'(1);
   assign o_terminal = (r_cnt == CNT_MAX);

endmodule

// File: rtl/strobe_rate_meter.sv
// Measures strobe period in clk cycles, tracks lock, flags mismatch and loss.
module strobe_rate_meter
   import strobe_rate_meter_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             stb_in,
   output logic [WIDTH-1:0] rate_out,
   output logic             rate_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout
);

   localparam int unsigned       RUN_W    = run_width(LOCK_COUNT);
   localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

   state_t           r_state;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_next;
   logic [WIDTH-1:0] w_period;
   logic             w_terminal;
   logic             w_clear;
   logic             w_same;

   // Counter is held at zero whenever there is no reference strobe.
   assign w_clear = !enable || (r_state == ST_IDLE);
   assign w_same  = (w_period == rate_out);

   strobe_period_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_stb     (stb_in),
      .o_period  (w_period),
      .o_terminal(w_terminal)
   );

   always_comb begin
      w_run_next = RUN_W'(1);
      if (w_same && (r_run != '0))
         w_run_next = (r_run == RUN_LOCK) ? r_run : r_run + RUN_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_run      <= '0;
         rate_out   <= '0;
         rate_valid <= 1'b0;
         locked     <= 1'b0;
         mismatch   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         mismatch   <= 1'b0;
         timeout    <= 1'b0;
         if (!enable) begin
            r_state <= ST_IDLE;
            r_run   <= '0;
            locked  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (stb_in)
                     r_state <= ST_ACQ;
               end
               ST_ACQ: begin
                  if (stb_in) begin
                     rate_out   <= w_period;
                     rate_valid <= 1'b1;
                     r_run      <= w_run_next;
                     if (w_run_next == RUN_LOCK) begin
                        locked  <= 1'b1;
                        r_state <= ST_LOCKED;
                     end
                  end else if (w_terminal) begin
                     timeout <= 1'b1;
                     locked  <= 1'b0;
                     r_run   <= '0;
                     r_state <= ST_IDLE;
                  end
               end
               ST_LOCKED: begin
                  if (stb_in) begin
                     rate_valid <= 1'b1;
                     if (!w_same) begin
                        rate_out <= w_period;
                        mismatch <= 1'b1;
                        locked   <= 1'b0;
                        r_run    <= RUN_W'(1);
                        r_state  <= ST_ACQ;
                     end
                  end else if (w_terminal) begin
                     timeout <= 1'b1;
                     locked  <= 1'b0;
                     r_run   <= '0;
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_strobe_rate_meter.sv
// Directed and randomized checks of strobe_rate_meter against a timestamp-based model.
module tb_strobe_rate_meter;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned LOCK_COUNT = 4;
   localparam int          TMO_GAP    = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             stb_in;
   logic [WIDTH-1:0] rate_out;
   logic             rate_valid;
   logic             locked;
   logic             mismatch;
   logic             timeout;

   always #5 clk = ~clk;

   strobe_rate_meter #(
      .WIDTH     (WIDTH),
      .LOCK_COUNT(LOCK_COUNT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .stb_in    (stb_in),
      .rate_out  (rate_out),
      .rate_valid(rate_valid),
      .locked    (locked),
      .mismatch  (mismatch),
      .timeout   (timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int tmo_seen = 0;
   bit chk_en   = 1'b0;

   // Model: timestamp of last accepted strobe plus a count of equal periods.
   bit m_ref  = 1'b0;
   int m_last = 0;
   int m_run  = 0;
   int m_rate = 0;
   bit m_valid, m_lock, m_mis, m_tmo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit s);
      int p;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      m_tmo   = 1'b0;
      if (r) begin
         m_ref = 1'b0; m_run = 0; m_rate = 0; m_lock = 1'b0;
      end else if (!e) begin
         m_ref = 1'b0; m_run = 0; m_lock = 1'b0;
      end else if (s) begin
         if (m_ref) begin
            p       = cyc - m_last;
            m_valid = 1'b1;
            if (m_lock && p != m_rate) begin
               m_mis  = 1'b1;
               m_lock = 1'b0;
               m_run  = 1;
               m_rate = p;
            end else if (!m_lock) begin
               m_run  = (m_run > 0 && p == m_rate) ? ((m_run < LOCK_COUNT) ? m_run + 1 : m_run) : 1;
               m_rate = p;
               if (m_run == LOCK_COUNT) m_lock = 1'b1;
            end
         end
         m_ref  = 1'b1;
         m_last = cyc;
      end else if (m_ref && (cyc - m_last) == TMO_GAP) begin
         m_tmo  = 1'b1;
         m_ref  = 1'b0;
         m_run  = 0;
         m_lock = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit s);
      rst    = r;
      enable = e;
      stb_in = s;
      @(posedge clk);
      model_step(r, e, s);
      cyc++;
      #1;
   endtask

   task automatic strobes(input int per, input int count);
      for (int k = 0; k < count; k++) begin
         repeat (per - 1) step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b1);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rate_out",   rate_out,   m_rate);
         check("rate_valid", rate_valid, m_valid);
         check("locked",     locked,     m_lock);
         check("mismatch",   mismatch,   m_mis);
         check("timeout",    timeout,    m_tmo);
         if (timeout === 1'b1) tmo_seen++;
      end
   end

   initial begin
      step(1'b1, 1'b0, 1'b0);
      chk_en = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      check("reset_rate", rate_out, 0);
      check("reset_locked", locked, 0);
      step(1'b0, 1'b1, 1'b0);

      strobes(5, 6);
      check("p5_rate", rate_out, 5);
      check("p5_locked", locked, 1);

      strobes(7, 1);
      check("p7_rate", rate_out, 7);
      check("p7_mismatch", mismatch, 1);
      check("p7_unlocked", locked, 0);
      strobes(7, 3);
      check("p7_relock", locked, 1);
      strobes(5, 4);
      check("p5_relock", locked, 1);

      tmo_seen = 0;
      repeat (TMO_GAP - 1) step(1'b0, 1'b1, 1'b0);
      check("tmo_early", timeout, 0);
      step(1'b0, 1'b1, 1'b0);
      check("tmo_pulse", timeout, 1);
      check("tmo_unlock", locked, 0);
      check("tmo_rate_held", rate_out, 5);
      repeat (4) step(1'b0, 1'b1, 1'b0);
      check("tmo_count", tmo_seen, 1);

      strobes(5, 5);
      check("en_locked", locked, 1);
      step(1'b0, 1'b0, 1'b0);
      check("dis_unlock", locked, 0);
      check("dis_rate_held", rate_out, 5);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      strobes(5, 1);
      check("reen_no_valid", rate_valid, 0);
      strobes(5, 3);
      check("reen_not_yet", locked, 0);
      strobes(5, 1);
      check("reen_locked", locked, 1);

      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (TMO_GAP - 1) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("max_rate", rate_out, 255);
      check("max_valid", rate_valid, 1);
      check("max_no_tmo", timeout, 0);

      step(1'b0, 1'b0, 1'b0);
      repeat (6) step(1'b0, 1'b1, 1'b1);
      check("held_rate", rate_out, 1);
      check("held_valid", rate_valid, 1);
      check("held_locked", locked, 1);

      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("rst_rate", rate_out, 0);
      check("rst_valid", rate_valid, 0);
      check("rst_locked", locked, 0);

      for (int b = 0; b < 400; b++) begin
         int sel;
         int per;
         sel = int'($urandom_range(0, 19));
         if (sel == 0)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (sel == 1)
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         else begin
            per = (sel == 2) ? int'($urandom_range(250, 258)) : int'($urandom_range(1, 9));
            strobes(per, int'($urandom_range(1, 8)));
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
